memory_access_stage: RTL

Pipeline MEM stage directly downstream of `Execute`: captures Execute's `result`, `writeData`, `rdOut` and control fields, performs word/byte loads and stores over a ready/ack data-memory port, and registers the MEM/WB values that feed both writeback and Execute's forwarding inputs (`memWbRegWrite`, `memWbRd`, `memWbData`). Memory accesses are multi-cycle; the stage stalls upstream until the access completes.

---
 rtl/microprocessor_pkg.sv | 24 ++
 rtl/byte_lane_unit.sv | 40 ++++
 rtl/memory_access_stage.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/microprocessor_pkg.sv
// -----------------------------------------------------------------------------
// microprocessor_pkg
// Shared definitions for the pipeline stages:
//   - bit positions inside the writeback (2-bit) and memory-access (3-bit)
//     control bundles produced by Execute
//   - MEM stage FSM state encoding
// -----------------------------------------------------------------------------
package microprocessor_pkg;

    // writeBackControlIn bit positions
    localparam int REGWRITE = 1;
    localparam int MEMTOREG = 0;

    // memAccessControlIn bit positions
    localparam int MEMREAD  = 2;
    localparam int MEMWRITE = 1;
    localparam int BYTEMODE = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/byte_lane_unit.sv
// -----------------------------------------------------------------------------
// byte_lane_unit
// Combinational byte-lane steering for the MEM stage.
//   store side : st_byte_mode, st_offset, wr_data -> byte_en, st_data
//   load side  : ld_byte_mode, ld_offset, rd_data -> ld_data
// Byte stores replicate the low byte onto all four lanes so the memory only
// needs to honour byte_en. Byte loads pick lane ld_offset and zero-extend.
// -----------------------------------------------------------------------------
module byte_lane_unit (
    input  logic        st_byte_mode,
    input  logic [1:0]  st_offset,
    input  logic [31:0] wr_data,
    input  logic        ld_byte_mode,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rd_data,
    output logic [3:0]  byte_en,
    output logic [31:0] st_data,
    output logic [31:0] ld_data
);

    logic [7:0] lanes [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = rd_data[8*gi +: 8];
    end

    always_comb begin
        byte_en = 4'b1111;
        st_data = wr_data;
        ld_data = rd_data;
        if (st_byte_mode) begin
            byte_en = 4'b0001 << st_offset;
            st_data = {4{wr_data[7:0]}};
        end
        if (ld_byte_mode) begin
            ld_data = {24'd0, lanes[ld_offset]};
        end
    end

endmodule

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
// Pipeline MEM stage. Non-memory ops pass straight into the MEM/WB registers
// in one cycle. Loads/stores issue a registered request on the data-memory
// port and hold the pipeline (stall) until memAck; the MEM/WB registers carry
// a bubble while the access is outstanding.
//
// Ports:
//   clk, resetN                      clock, async active-low reset
//   writeBackControlIn[1:0]          {regWrite, memToReg}
//   memAccessControlIn[2:0]          {memRead, memWrite, byteMode}
//   result, writeData, rdIn          Execute outputs (address / store data / rd)
//   stall                            high while an access is outstanding
//   memReq/memWe/memAddr/memWdata/memByteEn, memAck/memRdata   memory port
//   memWbRegWrite/memWbRd/memWbData  MEM/WB registers (writeback + forwarding)
//   alignError, busError             sticky error flags
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES WAIT cycles without ack (sets busError). Without it the
// stage waits indefinitely and busError is tied low.
// -----------------------------------------------------------------------------
module memory_access_stage
    import microprocessor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [1:0]  writeBackControlIn,
    input  logic [2:0]  memAccessControlIn,
    input  logic [31:0] result,
    input  logic [31:0] writeData,
    input  logic [4:0]  rdIn,
    output logic        stall,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memByteEn,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        memWbRegWrite,
    output logic [4:0]  memWbRd,
    output logic [31:0] memWbData,
    output logic        alignError,
    output logic        busError
);

    mem_state_t  state_reg, state_next;
    logic        req_reg, req_next;
    logic        we_reg, we_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  be_reg, be_next;
    logic        wb_we_reg, wb_we_next;
    logic [4:0]  wb_rd_reg, wb_rd_next;
    logic [31:0] wb_data_reg, wb_data_next;
    logic        align_reg, align_next;

    // Fields of the outstanding access, needed when the ack arrives
    logic        lat_load_reg, lat_load_next;
    logic        lat_regwrite_reg, lat_regwrite_next;
    logic        lat_memtoreg_reg, lat_memtoreg_next;
    logic        lat_byte_reg, lat_byte_next;
    logic [1:0]  lat_offset_reg, lat_offset_next;
    logic [4:0]  lat_rd_reg, lat_rd_next;
    logic [31:0] lat_result_reg, lat_result_next;

    logic        is_mem;
    logic        byte_mode;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_ldata;

    assign is_mem    = memAccessControlIn[MEMREAD] | memAccessControlIn[MEMWRITE];
    assign byte_mode = memAccessControlIn[BYTEMODE];

    byte_lane_unit u_lanes (
        .st_byte_mode (byte_mode),
        .st_offset    (result[1:0]),
        .wr_data      (writeData),
        .ld_byte_mode (lat_byte_reg),
        .ld_offset    (lat_offset_reg),
        .rd_data      (memRdata),
        .byte_en      (lane_be),
        .st_data      (lane_wdata),
        .ld_data      (lane_ldata)
    );

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          bus_reg, bus_next;
`endif

    always_comb begin
        state_next        = state_reg;
        req_next          = req_reg;
        we_next           = we_reg;
        addr_next         = addr_reg;
        wdata_next        = wdata_reg;
        be_next           = be_reg;
        wb_we_next        = wb_we_reg;
        wb_rd_next        = wb_rd_reg;
        wb_data_next      = wb_data_reg;
        align_next        = align_reg;
        lat_load_next     = lat_load_reg;
        lat_regwrite_next = lat_regwrite_reg;
        lat_memtoreg_next = lat_memtoreg_reg;
        lat_byte_next     = lat_byte_reg;
        lat_offset_next   = lat_offset_reg;
        lat_rd_next       = lat_rd_reg;
        lat_result_next   = lat_result_reg;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_next          = cnt_reg;
        bus_next          = bus_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (!is_mem) begin
                    wb_we_next   = writeBackControlIn[REGWRITE];
                    wb_rd_next   = rdIn;
                    wb_data_next = result;
                end else if (!byte_mode && (result[1:0] != 2'b00)) begin
                    // Misaligned word access is dropped without touching memory
                    align_next = 1'b1;
                    wb_we_next = 1'b0;
                end else begin
                    state_next        = WAIT;
                    req_next          = 1'b1;
                    we_next           = memAccessControlIn[MEMWRITE];
                    addr_next         = {result[31:2], 2'b00};
                    wdata_next        = lane_wdata;
                    be_next           = lane_be;
                    wb_we_next        = 1'b0;
                    // memRead with memWrite also set behaves as a store
                    lat_load_next     = ~memAccessControlIn[MEMWRITE];
                    lat_regwrite_next = writeBackControlIn[REGWRITE];
                    lat_memtoreg_next = writeBackControlIn[MEMTOREG];
                    lat_byte_next     = byte_mode;
                    lat_offset_next   = result[1:0];
                    lat_rd_next       = rdIn;
                    lat_result_next   = result;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    cnt_next          = '0;
`endif
                end
            end
            WAIT: begin
                if (memAck) begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                    if (lat_load_reg) begin
                        wb_we_next   = lat_regwrite_reg;
                        wb_rd_next   = lat_rd_reg;
                        wb_data_next = lat_memtoreg_reg ? lane_ldata : lat_result_reg;
                    end else begin
                        wb_we_next = 1'b0;
                    end
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                    wb_we_next = 1'b0;
                    bus_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg        <= IDLE;
            req_reg          <= 1'b0;
            we_reg           <= 1'b0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            be_reg           <= '0;
            wb_we_reg        <= 1'b0;
            wb_rd_reg        <= '0;
            wb_data_reg      <= '0;
            align_reg        <= 1'b0;
            lat_load_reg     <= 1'b0;
            lat_regwrite_reg <= 1'b0;
            lat_memtoreg_reg <= 1'b0;
            lat_byte_reg     <= 1'b0;
            lat_offset_reg   <= '0;
            lat_rd_reg       <= '0;
            lat_result_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            req_reg          <= req_next;
            we_reg           <= we_next;
            addr_reg         <= addr_next;
            wdata_reg        <= wdata_next;
            be_reg           <= be_next;
            wb_we_reg        <= wb_we_next;
            wb_rd_reg        <= wb_rd_next;
            wb_data_reg      <= wb_data_next;
            align_reg        <= align_next;
            lat_load_reg     <= lat_load_next;
            lat_regwrite_reg <= lat_regwrite_next;
            lat_memtoreg_reg <= lat_memtoreg_next;
            lat_byte_reg     <= lat_byte_next;
            lat_offset_reg   <= lat_offset_next;
            lat_rd_reg       <= lat_rd_next;
            lat_result_reg   <= lat_result_next;
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_reg <= '0;
            bus_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            bus_reg <= bus_next;
        end
    end
    assign busError = bus_reg;
`else
    assign busError = 1'b0;
`endif

    assign stall         = (state_reg == WAIT);
    assign memReq        = req_reg;
    assign memWe         = we_reg;
    assign memAddr       = addr_reg;
    assign memWdata      = wdata_reg;
    assign memByteEn     = be_reg;
    assign memWbRegWrite = wb_we_reg;
    assign memWbRd       = wb_rd_reg;
    assign memWbData     = wb_data_reg;
    assign alignError    = align_reg;

endmodule
